// File: rtl/burst_cas_seq_if.sv
// -----------------------------------------------------------------------------
// burst_cas_seq_if
// Bus between the ACT sequencer and the column-command sequencer.
//   act_rdy    : one-clock pulse, ACT issued for this access (tRCD applies)
//   act_cas    : one-clock pulse, row hit (no tRCD)
//   act_rw     : access direction, 1 = write, 0 = read
//   act_addr   : {bg[1:0], ba[1:0], col[9:0]}
//   cas_rdy    : one-clock pulse, issue CAS now
//   cas_reg    : address of the CAS being issued
//   cas_rw     : direction of the most recently issued CAS
//   data_start : pulse on the first data clock of a burst
//   data_busy  : high during any data window
//   cas_idle   : nothing queued, in flight or on the data bus
//   cas_ovf    : sticky, a request was dropped on a full queue
// Modports: master = ACT sequencer side, slave = burst_cas_seq.
// -----------------------------------------------------------------------------
interface burst_cas_seq_if;
  logic        act_rdy;
  logic        act_cas;
  logic        act_rw;
  logic [13:0] act_addr;
  logic        cas_rdy;
  logic [13:0] cas_reg;
  logic        cas_rw;
  logic        data_start;
  logic        data_busy;
  logic        cas_idle;
  logic        cas_ovf;

  modport master (
    output act_rdy, act_cas, act_rw, act_addr,
    input  cas_rdy, cas_reg, cas_rw, data_start, data_busy, cas_idle, cas_ovf
  );

  modport slave (
    input  act_rdy, act_cas, act_rw, act_addr,
    output cas_rdy, cas_reg, cas_rw, data_start, data_busy, cas_idle, cas_ovf
  );
endinterface

// File: rtl/burst_cas_seq.sv
// -----------------------------------------------------------------------------
// burst_cas_seq
// DDR4 column-command sequencer. Queues up to two column accesses coming from
// the ACT sequencer, issues each CAS once its tRCD wait and the tCCD spacing
// have elapsed, and tracks the resulting data windows so the ACT side knows
// when precharge is safe.
//
// Ports:
//   clock_t : system clock, rising edge
//   reset   : synchronous, active-high
//   bus     : burst_cas_seq_if.slave (request inputs, CAS / data-window outputs)
//
// Optional feature: define CAS_WTR_EN to hold a read CAS until tWTR clocks
// after the end of the last write data window.
//
// A request arriving into an empty queue is considered for issue in its own
// arrival clock, so a row hit produces cas_rdy on the very next clock and an
// ACT produces cas_rdy exactly tRCD clocks later. All outputs are registered.
// -----------------------------------------------------------------------------
module burst_cas_seq #(
  parameter int tRCD = 16,
  parameter int tCCD = 4,
  parameter int CL   = 11,
  parameter int CWL  = 9,
  parameter int BL   = 8,
  parameter int tWTR = 6
) (
  input  logic               clock_t,
  input  logic               reset,
  burst_cas_seq_if.slave     bus
);

  localparam int HALF  = BL / 2;
  localparam int DEPTH = ((CL > CWL) ? CL : CWL) + HALF;

  // Injection patterns for the latency pipelines; bit 0 is "next clock".
  localparam logic [DEPTH-1:0] RD_START = DEPTH'(64'd1 << (CL - 1));
  localparam logic [DEPTH-1:0] WR_START = DEPTH'(64'd1 << (CWL - 1));
  localparam logic [DEPTH-1:0] RD_BUSY  = DEPTH'(((64'd1 << HALF) - 64'd1) << (CL - 1));
  localparam logic [DEPTH-1:0] WR_BUSY  = DEPTH'(((64'd1 << HALF) - 64'd1) << (CWL - 1));

  typedef struct packed {
    logic        rw;
    logic [13:0] addr;
    logic [4:0]  wait_cnt;  // clocks still to wait before this entry may issue
  } entry_t;

  function automatic logic [4:0] dec5(input logic [4:0] v);
    return (v == 5'd0) ? v : v - 5'd1;
  endfunction

  // Queue state
  entry_t      q     [2];
  entry_t      q_n   [2];
  logic [1:0]  count, count_n;

  // Spacing / latency state
  logic [3:0]       gap, gap_n;
  logic [DEPTH-1:0] start_sr, start_n;
  logic [DEPTH-1:0] busy_sr, busy_n;

  // Registered outputs
  logic        cas_rdy_q, cas_rw_q, rw_issued_q;
  logic [13:0] cas_reg_q;
  logic        data_start_q, data_busy_q, cas_idle_q, cas_ovf_q;

  // Combinational control
  logic   push_req, head_valid, issue, pop, bypass, accept, drop, rd_clear;
  entry_t in_entry, head;

`ifdef CAS_WTR_EN
  logic [DEPTH-1:0] wr_sr, wr_n;
  logic             wr_busy_q;
  logic [5:0]       wtr, wtr_n;

  // A read is held while any write burst is pending or on the bus, and then
  // for tWTR clocks after its last data clock.
  assign rd_clear = (wtr == 6'd0) && (wr_sr == '0) && !wr_busy_q;
`else
  localparam int unused_twtr = tWTR;
  assign rd_clear = 1'b1;
`endif

  // NOTE: every variable assigned here gets a default first, so no path
  // through the block leaves a value held and no latch is inferred.
  always_comb begin
    push_req          = bus.act_rdy | bus.act_cas;
    in_entry.rw       = bus.act_rw;
    in_entry.addr     = bus.act_addr;
    // act_rdy wins over act_cas; the arrival clock already counts as one.
    in_entry.wait_cnt = bus.act_rdy ? 5'(tRCD - 1) : 5'd0;

    head_valid = (count != 2'd0) || push_req;
    head       = (count != 2'd0) ? q[0] : in_entry;

    issue  = head_valid && (head.wait_cnt == 5'd0) && (gap == 4'd0) &&
             (head.rw || rd_clear);
    pop    = issue && (count != 2'd0);
    bypass = issue && (count == 2'd0);

    // All stored waits age every clock, head or not.
    for (int i = 0; i < 2; i++) begin
      q_n[i]          = q[i];
      q_n[i].wait_cnt = dec5(q[i].wait_cnt);
    end
    count_n = count;

    if (pop) begin
      q_n[0]  = q_n[1];
      count_n = count - 2'd1;
    end

    // A full queue still takes a push when the head leaves in the same clock.
    accept = push_req && !bypass && ((count != 2'd2) || pop);
    drop   = push_req && !bypass && !accept;

    if (accept) begin
      q_n[count_n[0]]          = in_entry;
      q_n[count_n[0]].wait_cnt = dec5(in_entry.wait_cnt);
      count_n                  = count_n + 2'd1;
    end

    gap_n = issue ? 4'(tCCD - 1) : ((gap == 4'd0) ? gap : gap - 4'd1);

    start_n = start_sr >> 1;
    busy_n  = busy_sr >> 1;
    if (issue) begin
      start_n = start_n | (head.rw ? WR_START : RD_START);
      busy_n  = busy_n  | (head.rw ? WR_BUSY  : RD_BUSY);
    end
  end

`ifdef CAS_WTR_EN
  always_comb begin
    wr_n = wr_sr >> 1;
    if (issue && head.rw) wr_n = wr_n | WR_BUSY;
    // Last clock of a write window: arm the turnaround counter.
    if (wr_busy_q && !wr_sr[0])
      wtr_n = 6'((tWTR > 0) ? tWTR - 1 : 0);
    else
      wtr_n = (wtr == 6'd0) ? wtr : wtr - 6'd1;
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      wr_sr     <= '0;
      wr_busy_q <= 1'b0;
      wtr       <= '0;
    end else begin
      wr_sr     <= wr_n;
      wr_busy_q <= wr_sr[0];
      wtr       <= wtr_n;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      // NOTE: queue entries are cleared as well as the count; the queue is two
      // small registers, not a RAM, and clearing keeps cas_reg deterministic.
      for (int i = 0; i < 2; i++) q[i] <= '0;
      count        <= '0;
      gap          <= '0;
      start_sr     <= '0;
      busy_sr      <= '0;
      cas_rdy_q    <= 1'b0;
      cas_reg_q    <= '0;
      rw_issued_q  <= 1'b0;
      cas_rw_q     <= 1'b0;
      data_start_q <= 1'b0;
      data_busy_q  <= 1'b0;
      cas_idle_q   <= 1'b1;
      cas_ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) q[i] <= q_n[i];
      count        <= count_n;
      gap          <= gap_n;
      start_sr     <= start_n;
      busy_sr      <= busy_n;
      cas_rdy_q    <= issue;
      cas_reg_q    <= issue ? head.addr : 14'd0;
      if (issue) rw_issued_q <= head.rw;
      // cas_rw follows one clock after the cas_rdy pulse.
      if (cas_rdy_q) cas_rw_q <= rw_issued_q;
      data_start_q <= start_sr[0];
      data_busy_q  <= busy_sr[0];
      cas_idle_q   <= (count_n == 2'd0) && (busy_n == '0) && !busy_sr[0] && !issue;
      cas_ovf_q    <= cas_ovf_q | drop;
    end
  end

  assign bus.cas_rdy    = cas_rdy_q;
  assign bus.cas_reg    = cas_reg_q;
  assign bus.cas_rw     = cas_rw_q;
  assign bus.data_start = data_start_q;
  assign bus.data_busy  = data_busy_q;
  assign bus.cas_idle   = cas_idle_q;
  assign bus.cas_ovf    = cas_ovf_q;

endmodule

// File: tb/tb_burst_cas_seq.sv
// -----------------------------------------------------------------------------
// tb_burst_cas_seq
// Directed bench for burst_cas_seq with default timing parameters
// (tRCD 16, tCCD 4, CL 11, CWL 9, BL 8, tWTR 6). Cycle t is the clock period
// after the t-th rising edge following reset release; inputs are driven for a
// whole cycle and outputs are sampled 1 time unit after the edge that opens it.
// Each output is logged per cycle into a 64-bit vector and compared with a
// hand-computed pattern.
// -----------------------------------------------------------------------------
module tb_burst_cas_seq;

  logic clock_t = 1'b0;
  logic reset   = 1'b0;

  burst_cas_seq_if bus ();

  burst_cas_seq dut (
    .clock_t (clock_t),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock_t = ~clock_t;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  logic [63:0] rdy_l, rw_l, start_l, busy_l, idle_l, ovf_l;
  logic [13:0] reg_l [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] win(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs, log this cycle's outputs, advance.
  task automatic cyc(input logic rdy, input logic cas, input logic rw,
                     input logic [13:0] addr, input logic rst);
    bus.act_rdy  = rdy;
    bus.act_cas  = cas;
    bus.act_rw   = rw;
    bus.act_addr = addr;
    reset        = rst;
    if (t < 64) begin
      rdy_l[t]   = bus.cas_rdy;
      rw_l[t]    = bus.cas_rw;
      start_l[t] = bus.data_start;
      busy_l[t]  = bus.data_busy;
      idle_l[t]  = bus.cas_idle;
      ovf_l[t]   = bus.cas_ovf;
      reg_l[t]   = bus.cas_reg;
    end
    @(posedge clock_t);
    #1;
    t++;
    bus.act_rdy = 1'b0;
    bus.act_cas = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic run_to(input int stop);
    while (t < stop) cyc(1'b0, 1'b0, 1'b0, 14'h0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 14'h0, 1'b1);
    t       = 0;
    rdy_l   = '0;
    rw_l    = '0;
    start_l = '0;
    busy_l  = '0;
    idle_l  = '0;
    ovf_l   = '0;
    for (int i = 0; i < 64; i++) reg_l[i] = '0;
  endtask

  initial begin
    bus.act_rdy  = 1'b0;
    bus.act_cas  = 1'b0;
    bus.act_rw   = 1'b0;
    bus.act_addr = '0;

    // Reset state
    do_reset();
    check("rst_cas_rdy",    64'(bus.cas_rdy),    64'd0);
    check("rst_cas_reg",    64'(bus.cas_reg),    64'd0);
    check("rst_cas_rw",     64'(bus.cas_rw),     64'd0);
    check("rst_data_start", 64'(bus.data_start), 64'd0);
    check("rst_data_busy",  64'(bus.data_busy),  64'd0);
    check("rst_cas_idle",   64'(bus.cas_idle),   64'd1);
    check("rst_cas_ovf",    64'(bus.cas_ovf),    64'd0);

    // ACT read at 10 -> CAS at 26, data 37..40, idle again at 41
    run_to(10);
    cyc(1'b1, 1'b0, 1'b0, 14'h0012, 1'b0);
    run_to(48);
    check("t1_cas_rdy",  rdy_l,           win(26, 26));
    check("t1_cas_reg",  64'(reg_l[26]),  64'h0012);
    check("t1_start",    start_l,         win(37, 37));
    check("t1_busy",     busy_l,          win(37, 40));
    check("t1_idle",     idle_l[47:0],    48'(win(0, 10) | win(41, 47)));
    check("t1_rw",       rw_l[47:0],      48'd0);

    // Row-hit write at 5 -> CAS at 6, cas_rw from 7, data 15..18
    do_reset();
    run_to(5);
    cyc(1'b0, 1'b1, 1'b1, 14'h2ABC, 1'b0);
    run_to(48);
    check("t2_cas_rdy",  rdy_l,           win(6, 6));
    check("t2_cas_reg",  64'(reg_l[6]),   64'h2ABC);
    check("t2_rw",       rw_l[47:0],      48'(win(7, 47)));
    check("t2_start",    start_l,         win(15, 15));
    check("t2_busy",     busy_l,          win(15, 18));
    check("t2_idle",     idle_l[47:0],    48'(win(0, 5) | win(19, 47)));

    // Two row-hit reads at 5, 6 -> CAS at 6 and 10, merged data 17..24
    do_reset();
    run_to(5);
    cyc(1'b0, 1'b1, 1'b0, 14'h0100, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 14'h3001, 1'b0);
    run_to(48);
    check("t3_cas_rdy",  rdy_l,           win(6, 6) | win(10, 10));
    check("t3_reg_a",    64'(reg_l[6]),   64'h0100);
    check("t3_reg_b",    64'(reg_l[10]),  64'h3001);
    check("t3_start",    start_l,         win(17, 17) | win(21, 21));
    check("t3_busy",     busy_l,          win(17, 24));
    check("t3_idle",     idle_l[47:0],    48'(win(0, 5) | win(25, 47)));

    // Three ACT reads at 5, 6, 7 -> third dropped, CAS at 21 and 25
    do_reset();
    run_to(5);
    cyc(1'b1, 1'b0, 1'b0, 14'h0A01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 14'h0A02, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 14'h0A03, 1'b0);
    run_to(48);
    check("t4_cas_rdy",  rdy_l,           win(21, 21) | win(25, 25));
    check("t4_reg_a",    64'(reg_l[21]),  64'h0A01);
    check("t4_reg_b",    64'(reg_l[25]),  64'h0A02);
    check("t4_ovf",      ovf_l[47:0],     48'(win(8, 47)));
    check("t4_busy",     busy_l,          win(32, 39));
    do_reset();
    check("t4_ovf_clear", 64'(bus.cas_ovf), 64'd0);

    // act_rdy and act_cas together at 5 -> one entry with tRCD, CAS at 21
    do_reset();
    run_to(5);
    cyc(1'b1, 1'b1, 1'b1, 14'h1555, 1'b0);
    run_to(48);
    check("t5_cas_rdy",  rdy_l,           win(21, 21));
    check("t5_cas_reg",  64'(reg_l[21]),  64'h1555);
    check("t5_rw",       rw_l[47:0],      48'(win(22, 47)));
    check("t5_busy",     busy_l,          win(30, 33));
    check("t5_ovf",      ovf_l,           64'd0);

    // Write at 5 then read at 6: turnaround only with CAS_WTR_EN
    do_reset();
    run_to(5);
    cyc(1'b0, 1'b1, 1'b1, 14'h0040, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 14'h0080, 1'b0);
    run_to(48);
`ifdef CAS_WTR_EN
    check("t6_cas_rdy",  rdy_l,           win(6, 6) | win(25, 25));
    check("t6_reg_rd",   64'(reg_l[25]),  64'h0080);
    check("t6_busy",     busy_l,          win(15, 18) | win(36, 39));
`else
    check("t6_cas_rdy",  rdy_l,           win(6, 6) | win(10, 10));
    check("t6_reg_rd",   64'(reg_l[10]),  64'h0080);
    check("t6_busy",     busy_l,          win(15, 18) | win(21, 24));
`endif
    check("t6_rw_first", 64'(rw_l[7]),    64'd1);

    // Reset at 20 during a read burst with a CAS still queued
    do_reset();
    run_to(5);
    cyc(1'b0, 1'b1, 1'b0, 14'h00AA, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 14'h00BB, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 14'h00CC, 1'b0);
    run_to(20);
    cyc(1'b0, 1'b0, 1'b0, 14'h0, 1'b1);
    run_to(48);
    check("t7_cas_rdy",  rdy_l,           win(6, 6) | win(10, 10));
    check("t7_start",    start_l,         win(17, 17));
    check("t7_busy",     busy_l,          win(17, 20));
    check("t7_idle",     idle_l[47:0],    48'(win(0, 5) | win(21, 47)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
